// File: rtl/booth_pkg.sv
// booth_pkg: shared state/digit types and radix-4 Booth recoding for the Booth multiplier.
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_t;
  function automatic digit_t booth_recode(input logic [2:0] g);
    return (g == 3'b001 || g == 3'b010) ? P1 :
           (g == 3'b011)                ? P2 :
           (g == 3'b100)                ? M2 :
           (g == 3'b101 || g == 3'b110) ? M1 : ZERO;
  endfunction
endpackage

// File: rtl/booth_r4_recode_add.sv
// booth_r4_recode_add: recodes one Booth group and adds digit*M to the accumulator.
module booth_r4_recode_add
  import booth_pkg::*;
#(
  parameter int W2 = 10
) (
  input  logic [2:0]  i_grp,
  input  logic [W2-1:0] i_m,
  input  logic [W2:0] i_a,
  output logic [W2:0] o_a
);
  digit_t      w_dig;
  logic [W2:0] w_m1, w_m2, w_addend;
  assign w_dig = booth_recode(i_grp);
  assign w_m1  = {i_m[W2-1], i_m};
  assign w_m2  = {i_m, 1'b0};
  always_comb
    w_addend = (w_dig == P1) ? w_m1 :
               (w_dig == P2) ? w_m2 :
               (w_dig == M1) ? -w_m1 :
               (w_dig == M2) ? -w_m2 : '0;
  assign o_a = i_a + w_addend;
endmodule

// File: rtl/booth_r4_mult_param.sv
// booth_r4_mult_param: sequential radix-4 Booth multiplier, signed/unsigned, go/over handshake.
module booth_r4_mult_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               go,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               over,
  output logic [2*WIDTH-1:0] product
);
  localparam int W2   = WIDTH + 2;
  localparam int ITER = W2 / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);
  state_t              r_state;
  logic [W2-1:0]       r_m, r_q;
  logic [W2:0]         r_a;
  logic                r_qm1, r_busy, r_over;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_product;
  logic [W2-1:0]       w_mx, w_qx;
  logic [W2:0]         w_a;
  logic [2*W2+1:0]     w_sh;
  // Two extra bits keep unsigned max operands positive so one Booth datapath serves both modes
  assign w_mx = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign w_qx = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
  booth_r4_recode_add #(.W2(W2)) u_recode_add (
    .i_grp({r_q[1:0], r_qm1}),
    .i_m  (r_m),
    .i_a  (r_a),
    .o_a  (w_a)
  );
  assign w_sh = $signed({w_a, r_q, r_qm1}) >>> 2;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_a       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_over    <= 1'b0;
      r_product <= '0;
    end else begin
      r_over <= 1'b0;
      case (r_state)
        IDLE: if (go) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
          r_a     <= '0;
          r_q     <= w_qx;
          r_qm1   <= 1'b0;
          r_m     <= w_mx;
          r_cnt   <= ITER_C;
        end
        RUN: begin
          r_a   <= w_sh[2*W2+1:W2+1];
          r_q   <= w_sh[W2:1];
          r_qm1 <= w_sh[0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state   <= DONE;
            r_over    <= 1'b1;
            r_product <= w_sh[2*WIDTH:1];
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy    = r_busy;
  assign over    = r_over;
  assign product = r_product;
endmodule

// File: tb/tb_booth_r4_mult_param.sv
// tb_booth_r4_mult_param: vector table, handshake corner sequences and random model check (WIDTH 8 and 16).
module tb_booth_r4_mult_param;
  logic clk = 1'b0, clr = 1'b0;
  logic go8 = 1'b0, sm8 = 1'b0, go16 = 1'b0, sm16 = 1'b0;
  logic [7:0]  q8 = '0, m8 = '0;
  logic [15:0] q16 = '0, m16 = '0;
  logic        busy8, over8, busy16, over16;
  logic [15:0] p8;
  logic [31:0] p16;
  int checks = 0, errors = 0;
  typedef struct {
    bit sm; logic [7:0] q, m; logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];
  booth_r4_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .go(go8), .signed_mode(sm8), .multiplier(q8), .multiplicand(m8),
    .busy(busy8), .over(over8), .product(p8));
  booth_r4_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .go(go16), .signed_mode(sm16), .multiplier(q16), .multiplicand(m16),
    .busy(busy16), .over(over16), .product(p16));
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [31:0] model(bit sm, int w, logic [15:0] q, logic [15:0] m);
    longint a, b;
    a = sm ? ((w == 8) ? longint'($signed(q[7:0])) : longint'($signed(q))) : longint'(q);
    b = sm ? ((w == 8) ? longint'($signed(m[7:0])) : longint'($signed(m))) : longint'(m);
    return (w == 8) ? {16'h0, 16'((a * b) & 64'hFFFF)} : 32'((a * b) & 64'hFFFF_FFFF);
  endfunction
  task automatic do_op(input bit w16, input bit sm, input logic [15:0] q, input logic [15:0] m,
                       output logic [31:0] p, output int lat, output int busyc, output int overc);
    @(negedge clk);
    if (w16) begin go16 = 1; sm16 = sm; q16 = q; m16 = m; end
    else begin go8 = 1; sm8 = sm; q8 = q[7:0]; m8 = m[7:0]; end
    lat = -1; busyc = 0; overc = 0; p = '0;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin go8 = 0; go16 = 0; end
      if (w16 ? busy16 : busy8) busyc++;
      if (w16 ? over16 : over8) begin
        overc++;
        if (lat < 0) begin lat = n - 1; p = w16 ? p16 : {16'h0, p8}; end
      end
    end
  endtask
  initial begin
    logic [31:0] p;
    int lat, bc, oc;
    vecs.push_back('{0, 8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{1, 8'h80, 8'h80, 16'h4000});
    vecs.push_back('{1, 8'hFF, 8'hFF, 16'h0001});
    vecs.push_back('{1, 8'h7F, 8'h80, 16'hC080});
    vecs.push_back('{1, 8'h80, 8'h7F, 16'hC080});
    vecs.push_back('{0, 8'h80, 8'h03, 16'h0180});
    vecs.push_back('{1, 8'h80, 8'h03, 16'hFE80});
    vecs.push_back('{0, 8'h00, 8'h5A, 16'h0000});
    vecs.push_back('{1, 8'h00, 8'hA5, 16'h0000});
    vecs.push_back('{0, 8'h81, 8'hFF, 16'h807F});
    vecs.push_back('{1, 8'h05, 8'hFD, 16'hFFF1});
    #12;
    check("reset busy8", busy8, 0);
    check("reset over8", over8, 0);
    check("reset product8", p8, 0);
    check("reset busy16", busy16, 0);
    check("reset product16", p16, 0);
    @(negedge clk) clr = 1;
    foreach (vecs[i]) begin
      do_op(0, vecs[i].sm, {8'h0, vecs[i].q}, {8'h0, vecs[i].m}, p, lat, bc, oc);
      check($sformatf("vec%0d product", i), p, {16'h0, vecs[i].exp});
      check($sformatf("vec%0d latency", i), lat, 5);
      check($sformatf("vec%0d busy cycles", i), bc, 6);
      check($sformatf("vec%0d over pulses", i), oc, 1);
    end
    // go and operands wiggled during RUN must not disturb the captured operation
    @(negedge clk);
    go8 = 1; sm8 = 0; q8 = 8'h12; m8 = 8'h34;
    @(posedge clk);
    oc = 0; p = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 3) begin go8 = 1; q8 = 8'hFF; m8 = 8'hEE; sm8 = 1; end else go8 = 0;
      if (over8) begin oc++; p = {16'h0, p8}; end
    end
    check("busy-ignore product", p, 32'h03A8);
    check("busy-ignore over pulses", oc, 1);
    repeat (3) @(negedge clk);
    check("product held idle", p8, 16'h03A8);
    go8 = 1; sm8 = 0; q8 = 8'h02; m8 = 8'h03;
    @(posedge clk);
    @(negedge clk) go8 = 0;
    @(negedge clk);
    check("product held in RUN", p8, 16'h03A8);
    repeat (10) @(negedge clk);
    check("next op product", p8, 16'h0006);
    // asynchronous abort two cycles into RUN
    go8 = 1; sm8 = 1; q8 = 8'h80; m8 = 8'h80;
    @(posedge clk);
    @(negedge clk) go8 = 0;
    @(negedge clk);
    check("busy before abort", busy8, 1);
    #2 clr = 0;
    #1;
    check("abort busy", busy8, 0);
    check("abort over", over8, 0);
    check("abort product", p8, 0);
    oc = 0;
    repeat (6) begin @(negedge clk); if (over8) oc++; end
    check("abort no over", oc, 0);
    clr = 1;
    do_op(0, 1, 16'h00F9, 16'h0007, p, lat, bc, oc);
    check("post-abort product", p, 32'h0000FFCF);
    check("post-abort latency", lat, 5);
    do_op(1, 1, 16'h8000, 16'h8000, p, lat, bc, oc);
    check("w16 min*min", p, 32'h4000_0000);
    check("w16 min*min latency", lat, 9);
    do_op(1, 0, 16'hFFFF, 16'hFFFF, p, lat, bc, oc);
    check("w16 max*max", p, 32'hFFFE_0001);
    check("w16 busy cycles", bc, 10);
    for (int i = 0; i < 2000; i++) begin
      bit sm;
      logic [15:0] q, m;
      sm = 1'($urandom);
      q = 16'($urandom);
      m = 16'($urandom);
      do_op(1, sm, q, m, p, lat, bc, oc);
      check($sformatf("rand%0d sm=%0d %0h*%0h", i, sm, q, m), p, model(sm, 16, q, m));
      check($sformatf("rand%0d latency/pulses", i), {lat, oc}, {32'd9, 32'd1});
    end
    for (int i = 0; i < 50; i++) begin
      bit sm;
      logic [15:0] q, m;
      sm = 1'($urandom);
      q = {8'h0, 8'($urandom)};
      m = {8'h0, 8'($urandom)};
      do_op(0, sm, q, m, p, lat, bc, oc);
      check($sformatf("rand8_%0d sm=%0d %0h*%0h", i, sm, q[7:0], m[7:0]), p, model(sm, 8, q, m));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
